// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with majority vote, runtime parity/stop modes and a valid/ready output FIFO
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          tick_os,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_perr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          framing_err,
  output logic                          break_det,
  output logic                          overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;
  state_t state;
  logic rx_m, rx_s, vote, pm_en, pm_odd, ts, sbit, sbad, zero, perr, push, pop, full, wr;
  logic [2:0] hist;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitn;
  logic [DATA_BITS-1:0] data;
  logic [DATA_BITS:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign push = tick_os && state == STOP && cnt == FULL && (sbit || !ts) && vote && !sbad;
  assign full = fifo_level == (AW + 1)'(FIFO_DEPTH);
  assign m_valid = fifo_level != '0;
  assign pop = m_valid && m_ready;
  assign wr = push && (!full || pop);
  assign m_data = m_valid ? mem[rp][DATA_BITS-1:0] : '0;
  assign m_perr = m_valid && mem[rp][DATA_BITS];
  always_ff @(posedge clk) begin
    framing_err <= 1'b0;
    break_det <= 1'b0;
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      hist <= 3'b111;
      state <= IDLE;
      cnt <= '0;
      bitn <= '0;
      data <= '0;
      pm_en <= 1'b0;
      pm_odd <= 1'b0;
      ts <= 1'b0;
      sbit <= 1'b0;
      sbad <= 1'b0;
      zero <= 1'b0;
      perr <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (tick_os) begin
        hist <= {hist[1:0], rx_s};
        cnt <= cnt == FULL ? '0 : cnt + 1'b1;
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            cnt <= '0;
          end
          START: if (cnt == HALF) begin
            cnt <= '0;
            state <= vote ? IDLE : DATA;
            pm_en <= ^parity_mode;
            pm_odd <= parity_mode == 2'b10;
            ts <= two_stop;
            bitn <= '0;
            zero <= 1'b1;
            sbit <= 1'b0;
            sbad <= 1'b0;
            perr <= 1'b0;
          end
          DATA: if (cnt == FULL) begin
            data <= {vote, data[DATA_BITS-1:1]};
            zero <= zero & ~vote;
            bitn <= bitn + 1'b1;
            if (bitn == LAST) state <= pm_en ? PARITY : STOP;
          end
          PARITY: if (cnt == FULL) begin
            perr <= (^data ^ vote) != pm_odd;
            zero <= zero & ~vote;
            state <= STOP;
          end
          STOP: if (cnt == FULL) begin
            if (ts && !sbit) begin
              sbit <= 1'b1;
              sbad <= ~vote;
              zero <= zero & ~vote;
            end else if (vote && !sbad) begin
              state <= IDLE;
            end else begin
              // an all-zero frame is a line break, anything else a framing error
              state <= RECOVER;
              break_det <= zero & ~vote;
              framing_err <= ~(zero & ~vote);
            end
          end
          RECOVER: if (rx_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    overrun <= 1'b0;
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= {perr, data};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      overrun <= push && full && !pop;
      fifo_level <= fifo_level + (AW + 1)'(wr) - (AW + 1)'(pop);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vector bench for uart_rx_fifo (OS=16, 8 data bits, depth 8, tick every 4 clocks)
module tb_uart_rx_fifo;
  localparam int BIT = 64;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, tick_os = 1'b0, two_stop = 1'b0, m_ready = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic [7:0] m_data;
  logic m_perr, m_valid, framing_err, break_det, overrun;
  logic [3:0] fifo_level;
  logic [3:0] prev_level = 4'd0;
  int checks = 0, failures = 0, fe_cnt = 0, brk_cnt = 0, ovr_cnt = 0, cyc = 0, last_inc = 0;
  int t0, off;
  logic [8:0] popq [$];
  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic pb;
    logic [7:0] ed;
    logic ep;
  } vec_t;
  vec_t vecs [8];
  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tick_os(tick_os), .parity_mode(parity_mode),
    .two_stop(two_stop), .m_data(m_data), .m_perr(m_perr), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .framing_err(framing_err), .break_det(break_det), .overrun(overrun)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    repeat (3) @(negedge clk);
    tick_os = 1'b1;
    @(negedge clk);
    tick_os = 1'b0;
  end
  initial forever begin
    @(negedge clk);
    #2;
    if (framing_err) fe_cnt++;
    if (break_det) brk_cnt++;
    if (overrun) ovr_cnt++;
    if (m_valid && m_ready) popq.push_back({m_perr, m_data});
    if (fifo_level > prev_level) last_inc = cyc;
    prev_level = fifo_level;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pb,
                            input logic s2en, input logic s2, input int gbit);
    logic q [$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pen) q.push_back(pb);
    q.push_back(1'b1);
    if (s2en) q.push_back(s2);
    q.push_back(1'b1);
    foreach (q[i]) begin
      rx = q[i];
      if (i == gbit) begin
        repeat (28) @(negedge clk);
        rx = ~q[i];
        repeat (4) @(negedge clk);
        rx = q[i];
        repeat (32) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
  endtask
  task automatic pop1();
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask
  initial begin
    vecs[0] = '{8'h3C, 2'b00, 1'b0, 8'h3C, 1'b0};
    vecs[1] = '{8'h07, 2'b01, 1'b0, 8'h07, 1'b1};
    vecs[2] = '{8'h07, 2'b01, 1'b1, 8'h07, 1'b0};
    vecs[3] = '{8'h07, 2'b10, 1'b0, 8'h07, 1'b0};
    vecs[4] = '{8'h00, 2'b10, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 2'b11, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h80, 2'b01, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'h96, 2'b10, 1'b0, 8'h96, 1'b1};
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_perr", 32'(m_perr), 0);
    check("rst_level", 32'(fifo_level), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    m_ready = 1'b0;
    check("stream_count", 32'(popq.size()), 2);
    check("stream_first", 32'(popq.size() > 0 ? popq[0] : 9'h1FF), 'hA5);
    check("stream_second", 32'(popq.size() > 1 ? popq[1] : 9'h1FF), 'h3C);
    popq.delete();
    foreach (vecs[i]) begin
      parity_mode = vecs[i].pm;
      send_frame(vecs[i].d, vecs[i].pm == 2'b01 || vecs[i].pm == 2'b10, vecs[i].pb, 1'b0, 1'b0, -1);
      check($sformatf("vec%0d_valid", i), 32'(m_valid), 1);
      check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].ed));
      check($sformatf("vec%0d_perr", i), 32'(m_perr), 32'(vecs[i].ep));
      check($sformatf("vec%0d_level", i), 32'(fifo_level), 1);
      pop1();
      check($sformatf("vec%0d_drained", i), 32'(fifo_level), 0);
    end
    parity_mode = 2'b00;
    popq.delete();
    check("clean_fe", 32'(fe_cnt), 0);
    check("clean_brk", 32'(brk_cnt), 0);
    check("clean_ovr", 32'(ovr_cnt), 0);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_level", 32'(fifo_level), 0);
    check("glitch_fe", 32'(fe_cnt), 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    check("vote_data", 32'(m_data), 'h5A);
    check("vote_level", 32'(fifo_level), 1);
    pop1();
    rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("break_pulses", 32'(brk_cnt), 1);
    check("break_fe", 32'(fe_cnt), 0);
    check("break_level", 32'(fifo_level), 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check("after_break_data", 32'(m_data), 'h55);
    check("after_break_level", 32'(fifo_level), 1);
    pop1();
    popq.delete();
    for (int i = 1; i <= 7; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, -1);
    t0 = cyc;
    send_frame(8'h08, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    off = last_inc - t0;
    check("fill_level", 32'(fifo_level), 8);
    send_frame(8'h09, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check("ovr_level", 32'(fifo_level), 8);
    check("ovr_pulses", 32'(ovr_cnt), 1);
    check("ovr_head", 32'(m_data), 'h01);
    t0 = cyc;
    fork
      send_frame(8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      begin
        while (cyc < t0 + off - 1) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
      end
    join
    check("fullpop_ovr", 32'(ovr_cnt), 1);
    check("fullpop_level", 32'(fifo_level), 8);
    check("fullpop_popped", 32'(popq.size() > 0 ? popq[0] : 9'h1FF), 'h01);
    m_ready = 1'b1;
    repeat (12) @(negedge clk);
    m_ready = 1'b0;
    check("drain_level", 32'(fifo_level), 0);
    check("drain_count", 32'(popq.size()), 9);
    check("drain_eighth", 32'(popq.size() > 7 ? popq[7] : 9'h1FF), 'h08);
    check("drain_last", 32'(popq.size() > 8 ? popq[8] : 9'h1FF), 'h0A);
    two_stop = 1'b1;
    fork
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      begin
        repeat (3 * BIT) @(negedge clk);
        two_stop = 1'b0;
      end
    join
    check("stop2_fe", 32'(fe_cnt), 1);
    check("stop2_brk", 32'(brk_cnt), 1);
    check("stop2_level", 32'(fifo_level), 0);
    two_stop = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    two_stop = 1'b0;
    check("stop2_good_data", 32'(m_data), 'hC3);
    check("stop2_good_level", 32'(fifo_level), 1);
    fork
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      begin
        repeat (5 * BIT + 16) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_valid", 32'(m_valid), 0);
        check("midrst_level", 32'(fifo_level), 0);
        check("midrst_data", 32'(m_data), 0);
        rst_n = 1'b1;
      end
    join
    repeat (BIT) @(negedge clk);
    check("midrst_no_push", 32'(fifo_level), 0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check("postrst_data", 32'(m_data), 'h96);
    check("postrst_perr", 32'(m_perr), 0);
    check("postrst_level", 32'(fifo_level), 1);
    check("final_fe", 32'(fe_cnt), 1);
    check("final_ovr", 32'(ovr_cnt), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
